// File: rtl/nerv_lock_ctrl_pkg.sv
// Shared types and constants for the nerv lock controller slice.
// Optional feature macro used across the slice: NERV_ALARM_LATCH_EN (sticky alarm with alarm_clr).
package nerv_pkg;

    localparam int FAIL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UNLOCKED,
        ST_LOCKOUT
    } lock_state_t;

endpackage

// File: rtl/nerv_lock_ctrl_if.sv
// Requester-facing bundle of the lock controller: attempt handshake, policy inputs and status.
// With NERV_ALARM_LATCH_EN defined the bundle also carries alarm_clr.
interface nerv_lock_ctrl_if;
    import nerv_pkg::*;

    logic              attempt_valid;
    logic              match;
    logic              relock;
`ifdef NERV_ALARM_LATCH_EN
    logic              alarm_clr;
`endif
    logic              attempt_ready;
    logic              unlock;
    logic              lockout;
    logic              alarm;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output attempt_valid,
        output match,
        output relock,
`ifdef NERV_ALARM_LATCH_EN
        output alarm_clr,
`endif
        input  attempt_ready,
        input  unlock,
        input  lockout,
        input  alarm,
        input  fail_cnt
    );

    modport slave (
        input  attempt_valid,
        input  match,
        input  relock,
`ifdef NERV_ALARM_LATCH_EN
        input  alarm_clr,
`endif
        output attempt_ready,
        output unlock,
        output lockout,
        output alarm,
        output fail_cnt
    );

endinterface

// File: rtl/nerv_lock_ctrl_down_timer.sv
// Loadable down-counter shared by the unlock and lockout windows; zero_o flags an expired window.
module nerv_down_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // A load always wins; otherwise the count parks at zero once it gets there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/nerv_lock_ctrl.sv
// Clocked, rate-limited unlock policy on top of the combinational password match.
// Define NERV_ALARM_LATCH_EN for a sticky alarm cleared by alarm_clr; otherwise alarm mirrors lockout.
module nerv_lock_ctrl
    import nerv_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 16,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    nerv_lock_ctrl_if.slave bus
);

    localparam int MAX_WIN = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW      = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;

    localparam logic [TW-1:0]     UNL_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]     LCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] MAX_F    = FAIL_W'(MAX_FAILS);

    lock_state_t       state_q, state_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [FAIL_W:0]   failNext;
    logic              timerLoad;
    logic [TW-1:0]     timerVal;
    logic              timerZero;

    nerv_down_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timerLoad),
        .load_val_i (timerVal),
        .zero_o     (timerZero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
        end
    end

    assign failNext = {1'b0, fail_q} + 1'b1;

    // Attempts are only evaluated in IDLE, so the counter never needs to move elsewhere except on expiry.
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        timerLoad = 1'b0;
        timerVal  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.attempt_valid) begin
                    if (bus.match) begin
                        state_d   = ST_UNLOCKED;
                        timerLoad = 1'b1;
                        timerVal  = UNL_LOAD;
                        fail_d    = '0;
                    end else if (failNext < {1'b0, MAX_F}) begin
                        fail_d = failNext[FAIL_W-1:0];
                    end else begin
                        state_d   = ST_LOCKOUT;
                        timerLoad = 1'b1;
                        timerVal  = LCK_LOAD;
                        fail_d    = MAX_F;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (bus.relock || timerZero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timerZero) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.attempt_ready = (state_q == ST_IDLE);
    assign bus.unlock        = (state_q == ST_UNLOCKED);
    assign bus.lockout       = (state_q == ST_LOCKOUT);
    assign bus.fail_cnt      = fail_q;

`ifdef NERV_ALARM_LATCH_EN
    logic alarm_q, alarm_d;

    // A fresh lockout entry beats a simultaneous clear.
    always_comb begin
        alarm_d = alarm_q;
        if (state_d == ST_LOCKOUT && state_q != ST_LOCKOUT) begin
            alarm_d = 1'b1;
        end else if (bus.alarm_clr) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign bus.alarm = alarm_q;
`else
    assign bus.alarm = (state_q == ST_LOCKOUT);
`endif

endmodule

// File: tb/tb_nerv_lock_ctrl.sv
// Self-checking bench for nerv_lock_ctrl: vector table, hand sequences and a randomized model comparison.
// Honors NERV_ALARM_LATCH_EN when defined at compile time.
module tb_nerv_lock_ctrl;
    import nerv_pkg::*;

    localparam int MAXF = 3;
    localparam int UNL  = 16;
    localparam int LCK  = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nerv_lock_ctrl_if bus ();

    nerv_lock_ctrl #(
        .MAX_FAILS      (MAXF),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LCK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: mode 0=idle 1=open 2=locked, remaining = window cycles left including this one.
    int mMode, mRem, mFails;
    bit mAlarm;

    function automatic void modelReset();
        mMode  = 0;
        mRem   = 0;
        mFails = 0;
        mAlarm = 1'b0;
    endfunction

    function automatic void modelStep(bit av, bit m, bit rl, bit clr);
        bit enterLock = 1'b0;
        case (mMode)
            0: if (av) begin
                if (m) begin
                    mMode = 1; mRem = UNL; mFails = 0;
                end else if (mFails + 1 < MAXF) begin
                    mFails++;
                end else begin
                    mMode = 2; mRem = LCK; mFails = MAXF; enterLock = 1'b1;
                end
            end
            1: if (rl || mRem == 1) mMode = 0; else mRem--;
            default: if (mRem == 1) begin mMode = 0; mFails = 0; end else mRem--;
        endcase
        if (enterLock) mAlarm = 1'b1;
        else if (clr) mAlarm = 1'b0;
    endfunction

    function automatic int expAlarm();
`ifdef NERV_ALARM_LATCH_EN
        return int'(mAlarm);
`else
        return (mMode == 2) ? 1 : 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge, the DUT samples them at the rising edge, outputs are read at the next falling edge.
    task automatic applyStimulus(input bit av, input bit m, input bit rl, input bit clr);
        bus.attempt_valid = av;
        bus.match         = m;
        bus.relock        = rl;
`ifdef NERV_ALARM_LATCH_EN
        bus.alarm_clr     = clr;
`endif
        @(posedge clk);
        modelStep(av, m, rl, clr);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".ready"},   int'(bus.attempt_ready), (mMode == 0) ? 1 : 0);
        check({tag, ".unlock"},  int'(bus.unlock),        (mMode == 1) ? 1 : 0);
        check({tag, ".lockout"}, int'(bus.lockout),       (mMode == 2) ? 1 : 0);
        check({tag, ".alarm"},   int'(bus.alarm),         expAlarm());
        check({tag, ".fail"},    int'(bus.fail_cnt),      mFails);
    endtask

    typedef struct {
        bit av, m, rl;
        bit unl, lk, rdy;
        int fails;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // av m rl | unlock lockout ready fail_cnt
        vecs[0] = '{1, 0, 0, 0, 0, 1, 1};
        vecs[1] = '{1, 0, 0, 0, 0, 1, 2};
        vecs[2] = '{1, 1, 0, 1, 0, 0, 0};
        vecs[3] = '{0, 0, 0, 1, 0, 0, 0};
        vecs[4] = '{1, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{0, 0, 0, 1, 0, 0, 0};
        vecs[6] = '{0, 0, 0, 1, 0, 0, 0};
        vecs[7] = '{0, 0, 1, 0, 0, 1, 0};
        vecs[8] = '{0, 0, 1, 0, 0, 1, 0};

        reset = 1'b1;
        bus.attempt_valid = 1'b0;
        bus.match         = 1'b0;
        bus.relock        = 1'b0;
`ifdef NERV_ALARM_LATCH_EN
        bus.alarm_clr     = 1'b0;
`endif
        modelReset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.ready",   int'(bus.attempt_ready), 1);
        check("rst.unlock",  int'(bus.unlock),        0);
        check("rst.lockout", int'(bus.lockout),       0);
        check("rst.alarm",   int'(bus.alarm),         0);
        check("rst.fail",    int'(bus.fail_cnt),      0);

        // Two misses, a hit, then relock sampled at window cycle 5.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].av, vecs[i].m, vecs[i].rl, 1'b0);
            check($sformatf("vec%0d.unlock", i),  int'(bus.unlock),        int'(vecs[i].unl));
            check($sformatf("vec%0d.lockout", i), int'(bus.lockout),       int'(vecs[i].lk));
            check($sformatf("vec%0d.ready", i),   int'(bus.attempt_ready), int'(vecs[i].rdy));
            check($sformatf("vec%0d.fail", i),    int'(bus.fail_cnt),      vecs[i].fails);
        end

        // Full unlock window length.
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < UNL; i++) begin
            check($sformatf("win%0d.unlock", i + 1), int'(bus.unlock), 1);
            applyStimulus(0, 0, 0, 0);
        end
        check("winEnd.unlock", int'(bus.unlock),        0);
        check("winEnd.ready",  int'(bus.attempt_ready), 1);
        check("winEnd.fail",   int'(bus.fail_cnt),      0);

        // Back-to-back misses into lockout; matching attempts during lockout are dropped.
        for (int i = 1; i <= MAXF; i++) begin
            applyStimulus(1, 0, 0, 0);
            check($sformatf("miss%0d.fail", i), int'(bus.fail_cnt), i);
        end
        for (int i = 0; i < LCK; i++) begin
            check($sformatf("lk%0d.lockout", i + 1), int'(bus.lockout), 1);
            check($sformatf("lk%0d.unlock", i + 1),  int'(bus.unlock),  0);
            check($sformatf("lk%0d.alarm", i + 1),   int'(bus.alarm),   1);
            check($sformatf("lk%0d.fail", i + 1),    int'(bus.fail_cnt), MAXF);
            applyStimulus(1, 1, 0, 0);
        end
        check("lkEnd.lockout", int'(bus.lockout),       0);
        check("lkEnd.fail",    int'(bus.fail_cnt),      0);
        check("lkEnd.ready",   int'(bus.attempt_ready), 1);
`ifdef NERV_ALARM_LATCH_EN
        check("lkEnd.alarmHeld", int'(bus.alarm), 1);
        applyStimulus(0, 0, 0, 0);
        check("lkEnd.alarmHeld2", int'(bus.alarm), 1);
        applyStimulus(0, 0, 0, 1);
        check("alarmClr.alarm", int'(bus.alarm), 0);
`else
        check("lkEnd.alarm", int'(bus.alarm), 0);
`endif

        // Asynchronous reset at window cycle 8, between clock edges.
        applyStimulus(1, 1, 0, 0);
        repeat (7) applyStimulus(0, 0, 0, 0);
        check("preRst.unlock", int'(bus.unlock), 1);
        #2 reset = 1'b1;
        #1;
        check("asyncRst.unlock", int'(bus.unlock),        0);
        check("asyncRst.ready",  int'(bus.attempt_ready), 1);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postRst");
        applyStimulus(1, 0, 0, 0);
        check("postRst.fail", int'(bus.fail_cnt), 1);

        // Random traffic biased toward misses so lockouts recur.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(bit'($urandom_range(0, 3) != 0),
                          bit'($urandom_range(0, 4) == 0),
                          bit'($urandom_range(0, 7) == 0),
                          bit'($urandom_range(0, 15) == 0));
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
